// File: rtl/dm_write_buffer_if.sv
// Signal bundle for the store write buffer: MEM-stage store/load side plus the
// data-memory write port and occupancy status.
interface dm_write_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              st_valid;
   logic [ADDR_W-1:0] st_addr;
   logic [DATA_W-1:0] st_data;
   logic [31:0]       st_pc;
   logic              st_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_hit;
   logic [DATA_W-1:0] ld_data;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [31:0]       dm_pc;
   logic              dm_ready;
   logic [CNT_W-1:0]  count;
   logic              empty;

   modport slave (
      input  st_valid, st_addr, st_data, st_pc, ld_addr, dm_ready,
      output st_ready, ld_hit, ld_data, dm_we, dm_addr, dm_wdata, dm_pc, count, empty
   );

   modport master (
      output st_valid, st_addr, st_data, st_pc, ld_addr, dm_ready,
      input  st_ready, ld_hit, ld_data, dm_we, dm_addr, dm_wdata, dm_pc, count, empty
   );
endinterface

// File: rtl/dm_write_buffer.sv
// FIFO store buffer between MEM stage and data memory, with youngest-match
// load forwarding from all pending entries.
module dm_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   dm_write_buffer_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [31:0]       pc_q   [DEPTH];
   logic [DEPTH-1:0]  valid;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  cnt;

   logic              full;
   logic              enq;
   logic              deq;
   logic              hit;
   logic [DATA_W-1:0] fwd;
   logic [PTR_W-1:0]  idx;
   logic              unused_ld_offset;

   assign full = (cnt == CNT_W'(DEPTH));
   assign enq  = bus.st_valid && !full;
   assign deq  = (cnt != '0) && bus.dm_ready;

   assign bus.st_ready = !full;
   assign bus.dm_we    = (cnt != '0);
   assign bus.dm_addr  = addr_q[rd_ptr];
   assign bus.dm_wdata = data_q[rd_ptr];
   assign bus.dm_pc    = pc_q[rd_ptr];
   assign bus.count    = cnt;
   assign bus.empty    = (cnt == '0);
   assign bus.ld_hit   = hit;
   assign bus.ld_data  = fwd;

   assign unused_ld_offset = ^bus.ld_addr[1:0];

   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      hit = 1'b0;
      fwd = '0;
      idx = rd_ptr;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PTR_W'(i);
         if (valid[idx] && (addr_q[idx][ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2])) begin
            hit = 1'b1;
            fwd = data_q[idx];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         valid  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         if (enq) begin
            addr_q[wr_ptr] <= bus.st_addr;
            data_q[wr_ptr] <= bus.st_data;
            pc_q[wr_ptr]   <= bus.st_pc;
            valid[wr_ptr]  <= 1'b1;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         // enq and deq never target the same slot: enq needs !full, deq needs !empty.
         if (deq) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + PTR_W'(1);
         end
         if (enq && !deq) begin
            cnt <= cnt + CNT_W'(1);
         end else if (deq && !enq) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_dm_write_buffer.sv
// Directed bench for dm_write_buffer: vector table for fill/drain/forwarding,
// plus hand sequences for reset, single store, pointer wrap and mid-drain reset.
module tb_dm_write_buffer;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   dm_write_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

   dm_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st_valid;
      logic [31:0] st_addr;
      logic [31:0] st_data;
      logic [31:0] ld_addr;
      logic        dm_ready;
      logic        exp_hit;
      logic [31:0] exp_ld;
      logic [2:0]  exp_count;
      logic        exp_we;
      logic [31:0] exp_dm_addr;
      logic        exp_rdy;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bif.st_valid = 1'b0;
      bif.st_addr  = '0;
      bif.st_data  = '0;
      bif.st_pc    = '0;
      bif.ld_addr  = '0;
      bif.dm_ready = 1'b0;

      // fill/drain vectors: inputs, then pre-edge forwarding and post-edge state
      vecs[0]  = '{1'b1, 32'h00, 32'h100, 32'h00, 1'b0, 1'b0, 32'h000, 3'd1, 1'b1, 32'h00, 1'b1};
      vecs[1]  = '{1'b1, 32'h04, 32'h104, 32'h00, 1'b0, 1'b1, 32'h100, 3'd2, 1'b1, 32'h00, 1'b1};
      vecs[2]  = '{1'b1, 32'h08, 32'h108, 32'h04, 1'b0, 1'b1, 32'h104, 3'd3, 1'b1, 32'h00, 1'b1};
      vecs[3]  = '{1'b1, 32'h0C, 32'h10C, 32'h09, 1'b0, 1'b1, 32'h108, 3'd4, 1'b1, 32'h00, 1'b0};
      vecs[4]  = '{1'b1, 32'h10, 32'h110, 32'h10, 1'b0, 1'b0, 32'h000, 3'd4, 1'b1, 32'h00, 1'b0};
      vecs[5]  = '{1'b1, 32'h14, 32'h114, 32'h00, 1'b1, 1'b1, 32'h100, 3'd3, 1'b1, 32'h04, 1'b1};
      vecs[6]  = '{1'b0, 32'h00, 32'h000, 32'h00, 1'b1, 1'b0, 32'h000, 3'd2, 1'b1, 32'h08, 1'b1};
      vecs[7]  = '{1'b0, 32'h00, 32'h000, 32'h04, 1'b1, 1'b0, 32'h000, 3'd1, 1'b1, 32'h0C, 1'b1};
      vecs[8]  = '{1'b0, 32'h00, 32'h000, 32'h0C, 1'b1, 1'b1, 32'h10C, 3'd0, 1'b0, 32'h00, 1'b1};
      vecs[9]  = '{1'b1, 32'h20, 32'h001, 32'h20, 1'b0, 1'b0, 32'h000, 3'd1, 1'b1, 32'h20, 1'b1};
      vecs[10] = '{1'b1, 32'h20, 32'h002, 32'h20, 1'b0, 1'b1, 32'h001, 3'd2, 1'b1, 32'h20, 1'b1};
      vecs[11] = '{1'b0, 32'h00, 32'h000, 32'h20, 1'b0, 1'b1, 32'h002, 3'd2, 1'b1, 32'h20, 1'b1};
      vecs[12] = '{1'b0, 32'h00, 32'h000, 32'h23, 1'b0, 1'b1, 32'h002, 3'd2, 1'b1, 32'h20, 1'b1};
      vecs[13] = '{1'b0, 32'h00, 32'h000, 32'h24, 1'b0, 1'b0, 32'h000, 3'd2, 1'b1, 32'h20, 1'b1};
      vecs[14] = '{1'b1, 32'h30, 32'h003, 32'h30, 1'b0, 1'b0, 32'h000, 3'd3, 1'b1, 32'h20, 1'b1};
      vecs[15] = '{1'b0, 32'h00, 32'h000, 32'h30, 1'b0, 1'b1, 32'h003, 3'd3, 1'b1, 32'h20, 1'b1};

      step();
      step();
      reset = 1'b0;

      // asynchronous reset between edges with one entry pending
      bif.st_valid = 1'b1;
      bif.st_addr  = 32'h44;
      bif.st_data  = 32'h55;
      bif.st_pc    = 32'h66;
      bif.ld_addr  = 32'h44;
      step();
      bif.st_valid = 1'b0;
      check("pre_reset_we", 64'(bif.dm_we), 64'd1);
      #3;
      reset = 1'b1;
      #1;
      check("rst_st_ready", 64'(bif.st_ready), 64'd1);
      check("rst_empty",    64'(bif.empty),    64'd1);
      check("rst_dm_we",    64'(bif.dm_we),    64'd0);
      check("rst_dm_addr",  64'(bif.dm_addr),  64'd0);
      check("rst_dm_wdata", 64'(bif.dm_wdata), 64'd0);
      check("rst_dm_pc",    64'(bif.dm_pc),    64'd0);
      check("rst_ld_hit",   64'(bif.ld_hit),   64'd0);
      check("rst_ld_data",  64'(bif.ld_data),  64'd0);
      check("rst_count",    64'(bif.count),    64'd0);
      step();
      reset = 1'b0;

      // single store, memory always ready
      bif.dm_ready = 1'b1;
      bif.st_valid = 1'b1;
      bif.st_addr  = 32'h0000_0010;
      bif.st_data  = 32'hDEAD_BEEF;
      bif.st_pc    = 32'h0000_3008;
      step();
      bif.st_valid = 1'b0;
      check("single_we",    64'(bif.dm_we),    64'd1);
      check("single_addr",  64'(bif.dm_addr),  64'h10);
      check("single_wdata", 64'(bif.dm_wdata), 64'hDEAD_BEEF);
      check("single_pc",    64'(bif.dm_pc),    64'h3008);
      check("single_count", 64'(bif.count),    64'd1);
      step();
      check("single_we_off", 64'(bif.dm_we), 64'd0);
      check("single_empty",  64'(bif.empty), 64'd1);
      check("single_cnt0",   64'(bif.count), 64'd0);

      reset_pulse();
      for (int i = 0; i < 16; i++) begin
         bif.st_valid = vecs[i].st_valid;
         bif.st_addr  = vecs[i].st_addr;
         bif.st_data  = vecs[i].st_data;
         bif.st_pc    = 32'h4000 + vecs[i].st_addr;
         bif.ld_addr  = vecs[i].ld_addr;
         bif.dm_ready = vecs[i].dm_ready;
         #1;
         check($sformatf("v%0d_ld_hit", i),  64'(bif.ld_hit),  64'(vecs[i].exp_hit));
         check($sformatf("v%0d_ld_data", i), 64'(bif.ld_data), 64'(vecs[i].exp_ld));
         step();
         check($sformatf("v%0d_count", i),    64'(bif.count),    64'(vecs[i].exp_count));
         check($sformatf("v%0d_dm_we", i),    64'(bif.dm_we),    64'(vecs[i].exp_we));
         check($sformatf("v%0d_st_ready", i), 64'(bif.st_ready), 64'(vecs[i].exp_rdy));
         check($sformatf("v%0d_empty", i),    64'(bif.empty),    64'(vecs[i].exp_count == 3'd0));
         if (vecs[i].exp_we)
            check($sformatf("v%0d_dm_addr", i), 64'(bif.dm_addr), 64'(vecs[i].exp_dm_addr));
      end
      bif.st_valid = 1'b0;

      // wrap: two queued, then enqueue+dequeue every cycle for 10 stores
      reset_pulse();
      bif.dm_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bif.st_valid = 1'b1;
         bif.st_addr  = 32'h100 + 32'(4 * k);
         bif.st_data  = 32'h1000 + 32'(k);
         bif.st_pc    = 32'h2000 + 32'(k);
         step();
      end
      bif.dm_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         bif.st_valid = 1'b1;
         bif.st_addr  = 32'h100 + 32'(4 * (j + 2));
         bif.st_data  = 32'h1000 + 32'(j + 2);
         bif.st_pc    = 32'h2000 + 32'(j + 2);
         bif.ld_addr  = 32'h100 + 32'(4 * (j + 1));
         #1;
         check($sformatf("wrap%0d_hit", j),  64'(bif.ld_hit),  64'd1);
         check($sformatf("wrap%0d_data", j), 64'(bif.ld_data), 64'(32'h1000 + 32'(j + 1)));
         step();
         check($sformatf("wrap%0d_count", j), 64'(bif.count),   64'd2);
         check($sformatf("wrap%0d_addr", j),  64'(bif.dm_addr), 64'(32'h100 + 32'(4 * (j + 1))));
         check($sformatf("wrap%0d_pc", j),    64'(bif.dm_pc),   64'(32'h2000 + 32'(j + 1)));
      end
      bif.st_valid = 1'b0;
      step();
      check("wrap_tail_addr",  64'(bif.dm_addr), 64'h12C);
      check("wrap_tail_count", 64'(bif.count),   64'd1);
      step();
      check("wrap_done_we", 64'(bif.dm_we), 64'd0);

      // reset in the middle of a drain
      reset_pulse();
      bif.dm_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bif.st_valid = 1'b1;
         bif.st_addr  = 32'h200 + 32'(4 * k);
         bif.st_data  = 32'h7000 + 32'(k);
         bif.st_pc    = 32'h8000 + 32'(k);
         step();
      end
      bif.st_valid = 1'b0;
      bif.dm_ready = 1'b1;
      check("mid_count3", 64'(bif.count), 64'd3);
      #3;
      reset = 1'b1;
      #1;
      check("mid_we",    64'(bif.dm_we), 64'd0);
      check("mid_count", 64'(bif.count), 64'd0);
      check("mid_empty", 64'(bif.empty), 64'd1);
      step();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("post_rst%0d_we", k),   64'(bif.dm_we),   64'd0);
         check($sformatf("post_rst%0d_addr", k), 64'(bif.dm_addr), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
